dmem_port_arbiter: RTL

Arbitrates the single data port of the shared `ram` between the CPU datapath (load/store path) and the FPGA host/calculator module, replacing the fixed enable-muxing of the address, data, write-enable and read-enable paths. It grants at most one requester per cycle and stalls the CPU whenever its access is not granted. It provides a host halt mode that freezes the CPU so the host can own memory. It also keeps a saturating contention counter for debug display.

---
 rtl/dmem_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Single data-port arbiter for the shared RAM: the CPU load/store path and the host
// compete for one port, with a host halt mode and a saturating contention counter.
module dmem_port_arbiter #(
   parameter int ADDR_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [31:0]       host_addr,
   input  logic [31:0]       host_wdata,
   input  logic              host_halt,
   output logic              host_ack,
   output logic [31:0]       host_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [31:0]       ram_rdata,
   output logic [CNT_W-1:0]  contention_cnt
);

   typedef enum logic {RUN, HALT} state_t;
   typedef enum logic {PRIO_CPU, PRIO_HOST} prio_t;

   state_t state_q, state_d;
   prio_t  prio_q, prio_d;
   logic   ack_pending;
   logic   cpu_req, cpu_elig, host_elig, both_elig;
   logic   grant_cpu, grant_host;

   // Address bits above the RAM width are deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{cpu_addr[31:ADDR_W], host_addr[31:ADDR_W]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         prio_q  <= PRIO_CPU;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      cpu_req    = cpu_rd | cpu_wr;
      cpu_elig   = cpu_req & (state_q == RUN);
      host_elig  = host_req & ~ack_pending;
      both_elig  = cpu_elig & host_elig;
      // Reset kills both grants so nothing granted in a reset cycle reaches the RAM.
      grant_cpu  = cpu_elig & (~host_elig | (prio_q == PRIO_CPU)) & ~rst;
      grant_host = host_elig & (~cpu_elig | (prio_q == PRIO_HOST)) & ~rst;

      state_d = host_halt ? HALT : RUN;
      prio_d  = prio_q;
      if (state_q == HALT && !host_halt)
         prio_d = PRIO_CPU;
      else if (both_elig)
         prio_d = grant_cpu ? PRIO_HOST : PRIO_CPU;

      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      if (grant_cpu) begin
         ram_addr  = cpu_addr[ADDR_W-1:0];
         ram_wdata = cpu_wdata;
         ram_we    = cpu_wr;
         ram_re    = ~cpu_wr;
      end else if (grant_host) begin
         ram_addr  = host_addr[ADDR_W-1:0];
         ram_wdata = host_wdata;
         ram_we    = host_we;
         ram_re    = ~host_we;
      end

      cpu_rdata = grant_cpu ? ram_rdata : '0;
      cpu_stall = (cpu_req & ~grant_cpu) | (state_q == HALT);
   end

   // ack_pending blocks the host for the ack cycle, so it completes at most every 2 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         ack_pending    <= 1'b0;
         host_ack       <= 1'b0;
         host_rdata     <= '0;
         contention_cnt <= '0;
      end else begin
         ack_pending <= grant_host;
         host_ack    <= grant_host;
         if (grant_host && !host_we)
            host_rdata <= ram_rdata;
         if (both_elig && !(&contention_cnt))
            contention_cnt <= contention_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
